// File: rtl/if_instr_queue.sv
// IF->ID decoupling FIFO: first-word-fall-through instruction queue that absorbs
// ICache returns while ID stalls, flushed as a unit on redirect.
module if_instr_queue #(
    parameter int DEPTH  = 4,
    parameter int EXC_W  = 8,
    parameter int PRES_W = 34
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [31:0]                fetch_instr,
    input  logic [31:0]                fetch_pc,
    input  logic [EXC_W-1:0]           fetch_except,
    input  logic [PRES_W-1:0]          fetch_presult,
    input  logic                       id_wr,
    output logic                       if_valid,
    output logic [31:0]                if_instr,
    output logic [31:0]                if_pc,
    output logic [EXC_W-1:0]           if_except,
    output logic [PRES_W-1:0]          if_presult,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]       r_instr   [DEPTH];
    logic [31:0]       r_pc      [DEPTH];
    logic [EXC_W-1:0]  r_except  [DEPTH];
    logic [PRES_W-1:0] r_presult [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Handshake status comes from registered occupancy only, so no
    // combinational path exists from id_wr or fetch_valid to fetch_ready.
    assign fetch_ready = (r_count != CW'(DEPTH));
    assign if_valid    = (r_count != '0);
    assign count       = r_count;

    assign w_push = fetch_valid & fetch_ready & ~flush;
    assign w_pop  = id_wr & if_valid & ~flush;

    // An empty queue presents a NOP with no exception to ID.
    assign if_instr   = if_valid ? r_instr[r_rptr]   : '0;
    assign if_pc      = if_valid ? r_pc[r_rptr]      : '0;
    assign if_except  = if_valid ? r_except[r_rptr]  : '0;
    assign if_presult = if_valid ? r_presult[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_instr[r_wptr]   <= fetch_instr;
            r_pc[r_wptr]      <= fetch_pc;
            r_except[r_wptr]  <= fetch_except;
            r_presult[r_wptr] <= fetch_presult;
        end
    end

endmodule

// File: tb/tb_if_instr_queue.sv
// Bench for if_instr_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_instr_queue;

    localparam int DEPTH  = 4;
    localparam int EXC_W  = 8;
    localparam int PRES_W = 34;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_instr;
    logic [31:0]       fetch_pc;
    logic [EXC_W-1:0]  fetch_except;
    logic [PRES_W-1:0] fetch_presult;
    logic              id_wr;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic [EXC_W-1:0]  if_except;
    logic [PRES_W-1:0] if_presult;
    logic [CW-1:0]     count;

    if_instr_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W), .PRES_W(PRES_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_except(fetch_except), .fetch_presult(fetch_presult),
        .id_wr(id_wr), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_except(if_except), .if_presult(if_presult),
        .count(count)
    );

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [EXC_W-1:0]  exc;
        logic [PRES_W-1:0] pres;
    } ent_t;

    ent_t q[$];
    bit   model_ok = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries, compared every cycle and then
    // advanced using the inputs that will be sampled at the coming rising edge.
    always @(negedge clk) begin
        ent_t h;
        bit   do_pop, do_push;
        if (model_ok) begin
            h = (q.size() != 0) ? q[0] : '0;
            chk("m_valid",   {63'd0, if_valid},     {63'd0, q.size() != 0});
            chk("m_ready",   {63'd0, fetch_ready},  {63'd0, q.size() != DEPTH});
            chk("m_count",   64'(count),            64'(q.size()));
            chk("m_instr",   64'(if_instr),         64'(h.instr));
            chk("m_pc",      64'(if_pc),            64'(h.pc));
            chk("m_except",  64'(if_except),        64'(h.exc));
            chk("m_presult", 64'(if_presult),       64'(h.pres));
            chk("m_count_le_depth", {63'd0, count <= CW'(DEPTH)}, 64'd1);
        end
        if (rst) begin
            q.delete();
            model_ok = 1;
        end else if (model_ok) begin
            if (flush) begin
                q.delete();
            end else begin
                do_pop  = id_wr && (q.size() != 0);
                do_push = fetch_valid && (q.size() != DEPTH);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{fetch_instr, fetch_pc, fetch_except, fetch_presult});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [EXC_W-1:0] exc);
        fetch_valid   = 1;
        fetch_pc      = pc;
        fetch_instr   = pc ^ 32'h5A5A_0000;
        fetch_except  = exc;
        fetch_presult = {2'b10, pc};
    endtask

    initial begin
        rst = 1; flush = 0; fetch_valid = 0; id_wr = 0;
        fetch_instr = 0; fetch_pc = 0; fetch_except = 0; fetch_presult = 0;
        tick();
        tick();
        rst = 0;

        // Reset then idle
        @(negedge clk);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_instr", 64'(if_instr), 64'd0);
        chk("rst_ready", {63'd0, fetch_ready}, 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        tick();

        // Streaming with ID always consuming
        offer(32'hBFC0_0000, 0);
        id_wr = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) offer(32'hBFC0_0000 + 32'(4 * (i + 1)), 0);
            else fetch_valid = 0;
            @(negedge clk);
            chk("stream_pc", 64'(if_pc), 64'(32'hBFC0_0000 + 32'(4 * i)));
            chk("stream_count", 64'(count), 64'd1);
            tick();
        end
        id_wr = 0;
        @(negedge clk);
        chk("stream_empty", 64'(count), 64'd0);
        tick();

        // Fill with ID stalled, fifth entry held back
        for (int k = 0; k < 4; k++) begin
            offer(32'h0000_0100 + 32'(4 * k), 0);
            tick();
        end
        offer(32'h0000_0110, 0);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", {63'd0, fetch_ready}, 64'd0);
        id_wr = 1;
        tick();
        id_wr = 0;
        @(negedge clk);
        chk("fullpop_count", 64'(count), 64'd3);
        chk("fullpop_ready", {63'd0, fetch_ready}, 64'd1);
        chk("fullpop_head", 64'(if_pc), 64'h104);
        tick();
        fetch_valid = 0;
        @(negedge clk);
        chk("fifth_count", 64'(count), 64'd4);
        id_wr = 1;
        for (int k = 0; k < 4; k++) tick();
        id_wr = 0;
        @(negedge clk);
        chk("drain_count", 64'(count), 64'd0);

        // Wrap-around at occupancy 2
        for (int k = 0; k < 2; k++) begin
            offer(32'h0000_0200 + 32'(4 * k), 0);
            tick();
        end
        id_wr = 1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h0000_0208 + 32'(4 * i), (i == 7) ? 8'h01 : 8'h00);
            @(negedge clk);
            chk("wrap_pc", 64'(if_pc), 64'(32'h0000_0200 + 32'(4 * i)));
            chk("wrap_except", 64'(if_except), (i == 9) ? 64'd1 : 64'd0);
            chk("wrap_count", 64'(count), 64'd2);
            tick();
        end
        fetch_valid = 0;
        tick();
        tick();
        id_wr = 0;

        // Flush in the middle of a burst
        for (int k = 0; k < 3; k++) begin
            offer(32'h0000_0400 + 32'(4 * k), 0);
            tick();
        end
        offer(32'hDEAD_0000, 8'hFF);
        id_wr = 1;
        flush = 1;
        @(negedge clk);
        chk("preflush_count", 64'(count), 64'd3);
        tick();
        flush = 0;
        fetch_valid = 0;
        id_wr = 0;
        @(negedge clk);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", {63'd0, if_valid}, 64'd0);
        chk("flush_instr", 64'(if_instr), 64'd0);
        chk("flush_ready", {63'd0, fetch_ready}, 64'd1);
        offer(32'h0000_0300, 0);
        tick();
        fetch_valid = 0;
        @(negedge clk);
        chk("postflush_pc", 64'(if_pc), 64'h300);
        chk("postflush_valid", {63'd0, if_valid}, 64'd1);
        id_wr = 1;
        tick();
        id_wr = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            fetch_valid   = ($urandom_range(0, 3) != 0);
            id_wr         = ($urandom_range(0, 2) != 0) && (c % 200 > 40);
            fetch_instr   = $urandom;
            fetch_pc      = $urandom;
            fetch_except  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            fetch_presult = {2'($urandom), 32'($urandom)};
            tick();
        end
        rst = 0; flush = 0; fetch_valid = 0; id_wr = 0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
